pot_scan_sched: RTL and testbench

//  Scheduler for the shared slide-pot A2D. Sequences conversions round-robin over six pots
//  (LP, B1, B2, B3, HP, VOLUME) through the SPI A2D engine and applies hysteresis.

---
 rtl/pot_scan_sched_pkg.sv | 46 ++++
 rtl/pot_scan_sched_if.sv | 14 +
 rtl/pot_scan_sched_timer.sv | 27 ++
 rtl/pot_scan_sched.sv | 147 ++++++++++++++
 tb/tb_pot_scan_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pot_scan_sched_pkg.sv
// Shared types and constants for the slide-pot A2D scan scheduler.
// Provides the scan order, the A2D channel map, FSM states and the hysteresis compare.
package pot_scan_sched_pkg;

    localparam int unsigned N_POT = 6;
    localparam int unsigned RES_W = 12;
    localparam int unsigned CH_W  = 3;

    // Scan order; the enum value is the index into the gain array.
    typedef enum logic [2:0] {
        LP  = 3'd0,
        B1  = 3'd1,
        B2  = 3'd2,
        B3  = 3'd3,
        HP  = 3'd4,
        VOL = 3'd5
    } pot_e;

    // A2D channel wired to each pot, indexed by pot_e.
    localparam logic [CH_W-1:0] POT_CHNL [N_POT] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        UPD   = 3'd3,
        GAP   = 3'd4
    } sched_st_e;

    // True when the new sample differs from the held one by at least hyst counts.
    function automatic logic hyst_pass(input logic [RES_W-1:0] nv,
                                       input logic [RES_W-1:0] held,
                                       input int unsigned      hyst);
        logic signed [RES_W:0] diff;
        logic        [RES_W:0] mag;
        diff = $signed({1'b0, nv}) - $signed({1'b0, held});
        mag  = diff[RES_W] ? (RES_W+1)'(-diff) : (RES_W+1)'(diff);
        return 32'(mag) >= hyst;
    endfunction

    // Round-robin successor in the scan order.
    function automatic pot_e next_pot(input pot_e p);
        return (p == VOL) ? LP : pot_e'(3'(p + 3'd1));
    endfunction

endpackage

// File: rtl/pot_scan_sched_if.sv
// Handshake between the scan scheduler and the SPI A2D engine.
// master = scheduler (issues conversions), slave = A2D engine (returns results).
interface pot_scan_sched_if;
    import pot_scan_sched_pkg::*;

    logic             strt_cnv;
    logic [CH_W-1:0]  chnnl;
    logic             cnv_cmplt;
    logic [RES_W-1:0] res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);

endinterface

// File: rtl/pot_scan_sched_timer.sv
// Shared down-counter used both as the conversion watchdog and the inter-conversion gap.
// A load of N-1 makes expired_c rise on the N-th cycle after the load cycle.
module pot_scan_sched_timer #(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired_c = (cnt == '0);

endmodule

// File: rtl/pot_scan_sched.sv
// Round-robin scheduler for the shared slide-pot A2D: sequences six conversions,
// applies hysteresis and holds one registered 12-bit gain per pot.
module pot_scan_sched
    import pot_scan_sched_pkg::*;
#(
    parameter int unsigned GAP_CYC = 512,
    parameter int unsigned TMO_CYC = 4096,
    parameter int unsigned HYST    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    pot_scan_sched_if.master       a2d,
    output logic [RES_W-1:0]       POT_LP,
    output logic [RES_W-1:0]       POT_B1,
    output logic [RES_W-1:0]       POT_B2,
    output logic [RES_W-1:0]       POT_B3,
    output logic [RES_W-1:0]       POT_HP,
    output logic [RES_W-1:0]       VOLUME,
    output logic                   gains_vld,
    output logic                   scan_done,
    output logic                   tmo_err
);

    localparam int unsigned TMR_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMO_LD = TMR_W'(TMO_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD = TMR_W'(GAP_CYC - 1);

    sched_st_e        state;
    pot_e             idx;
    pot_e             idx_nxt_c;
    logic [N_POT-1:0] seen;
    logic [RES_W-1:0] gain [N_POT];
    logic [RES_W-1:0] res_q;
    logic             strt_q;
    logic [CH_W-1:0]  chnl_q;
    logic             last_c;
    logic             wr_ok_c;
    logic             tmr_load_c;
    logic [TMR_W-1:0] tmr_val_c;
    logic             tmr_expired_c;

    assign idx_nxt_c = next_pot(idx);
    assign last_c    = (idx == VOL);
    // First write to a channel bypasses hysteresis so the held value starts from a real sample.
    assign wr_ok_c   = !seen[idx] || hyst_pass(res_q, gain[idx], HYST);

    // Timer reload: watchdog on conversion start, gap on either exit from a conversion.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = GAP_LD;
        unique case (state)
            START: begin
                tmr_load_c = 1'b1;
                tmr_val_c  = TMO_LD;
            end
            WAIT:    tmr_load_c = !a2d.cnv_cmplt && tmr_expired_c;
            UPD:     tmr_load_c = 1'b1;
            default: tmr_load_c = 1'b0;
        endcase
    end

    pot_scan_sched_timer #(.W(TMR_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load_c),
        .load_val  (tmr_val_c),
        .expired_c (tmr_expired_c)
    );

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= LP;
            seen      <= '0;
            res_q     <= '0;
            strt_q    <= 1'b0;
            chnl_q    <= POT_CHNL[LP];
            gains_vld <= 1'b0;
            scan_done <= 1'b0;
            tmo_err   <= 1'b0;
            for (int unsigned i = 0; i < N_POT; i++) begin
                gain[i] <= '0;
            end
        end else begin
            strt_q    <= 1'b0;
            scan_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        strt_q <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over a same-cycle watchdog expiry.
                    if (a2d.cnv_cmplt) begin
                        res_q <= a2d.res;
                        state <= UPD;
                    end else if (tmr_expired_c) begin
                        tmo_err   <= 1'b1;
                        scan_done <= last_c;
                        state     <= GAP;
                    end
                end
                UPD: begin
                    if (wr_ok_c) begin
                        gain[idx] <= res_q;
                    end
                    seen[idx] <= 1'b1;
                    gains_vld <= &(seen | (N_POT'(1) << idx));
                    scan_done <= last_c;
                    state     <= GAP;
                end
                GAP: begin
                    if (tmr_expired_c) begin
                        idx    <= idx_nxt_c;
                        chnl_q <= POT_CHNL[idx_nxt_c];
                        if (en) begin
                            strt_q <= 1'b1;
                            state  <= START;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a2d.strt_cnv = strt_q;
    assign a2d.chnnl    = chnl_q;

    assign POT_LP = gain[LP];
    assign POT_B1 = gain[B1];
    assign POT_B2 = gain[B2];
    assign POT_B3 = gain[B3];
    assign POT_HP = gain[HP];
    assign VOLUME = gain[VOL];

endmodule

// File: tb/tb_pot_scan_sched.sv
// Directed bench for pot_scan_sched: the bench plays the A2D engine and checks
// channel order, gains, hysteresis, timeout, enable drop, reset abort and tie-break.
module tb_pot_scan_sched;

    localparam int unsigned GAP = 16;
    localparam int unsigned TMO = 64;
    localparam int unsigned HYS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume;
    logic        gains_vld, scan_done, tmo_err;

    int n_chk  = 0;
    int n_pass = 0;

    int exp_ch [6] = '{1, 0, 4, 2, 3, 7};

    pot_scan_sched_if a2d ();

    pot_scan_sched #(.GAP_CYC(GAP), .TMO_CYC(TMO), .HYST(HYS)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a2d       (a2d),
        .POT_LP    (pot_lp),
        .POT_B1    (pot_b1),
        .POT_B2    (pot_b2),
        .POT_B3    (pot_b3),
        .POT_HP    (pot_hp),
        .VOLUME    (volume),
        .gains_vld (gains_vld),
        .scan_done (scan_done),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] gain_of(input int i);
        case (i)
            0:       return pot_lp;
            1:       return pot_b1;
            2:       return pot_b2;
            3:       return pot_b3;
            4:       return pot_hp;
            default: return volume;
        endcase
    endfunction

    // Wait (bounded) for strt_cnv, then check the channel it targets.
    task automatic start_conv(input string tag, input int ch, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        for (int k = 0; k < 200; k++) begin
            if (a2d.strt_cnv) begin
                found = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        check({tag, " strt"}, 32'(found), 32'd1);
        check({tag, " chnnl"}, 32'(a2d.chnnl), 32'(ch));
    endtask

    // Answer dly cycles after the start cycle; returns one cycle after the gain write.
    task automatic finish_conv(input int dly, input logic [11:0] val);
        repeat (dly) tick();
        a2d.cnv_cmplt = 1'b1;
        a2d.res       = val;
        tick();
        a2d.cnv_cmplt = 1'b0;
        tick();
    endtask

    task automatic do_conv(input string tag, input int p, input logic [11:0] val,
                           input logic [11:0] exp_gain);
        int w;
        start_conv(tag, exp_ch[p], w);
        finish_conv(20, val);
        check({tag, " gain"}, 32'(gain_of(p)), 32'(exp_gain));
    endtask

    initial begin
        int w;
        int strt_seen;
        rst           = 1'b1;
        en            = 1'b0;
        a2d.cnv_cmplt = 1'b0;
        a2d.res       = '0;
        repeat (3) tick();

        check("rst chnnl", 32'(a2d.chnnl), 32'd1);
        check("rst strt", 32'(a2d.strt_cnv), 32'd0);
        check("rst lp", 32'(pot_lp), 32'd0);
        check("rst vol", 32'(volume), 32'd0);
        check("rst vld", 32'(gains_vld), 32'd0);
        check("rst tmo", 32'(tmo_err), 32'd0);

        // 1: full scan, res = 100*(idx+1)
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start_conv($sformatf("t1 c%0d", i), exp_ch[i], w);
            if (i == 0) begin
                check("t1 first wait", 32'(w), 32'd1);
                tick();
                check("t1 strt pulse", 32'(a2d.strt_cnv), 32'd0);
                finish_conv(19, 12'(100 * (i + 1)));
            end else begin
                finish_conv(20, 12'(100 * (i + 1)));
            end
            check($sformatf("t1 gain%0d", i), 32'(gain_of(i)), 32'(100 * (i + 1)));
            check($sformatf("t1 vld%0d", i), 32'(gains_vld), 32'(i == 5));
            check($sformatf("t1 done%0d", i), 32'(scan_done), 32'(i == 5));
        end
        tick();
        check("t1 done pulse", 32'(scan_done), 32'd0);

        // 2: hysteresis around the HYST boundary
        do_conv("t2 lp+2", 0, 12'd102, 12'd100);
        do_conv("t2 b1-3", 1, 12'd197, 12'd200);
        do_conv("t2 b2-4", 2, 12'd296, 12'd296);
        do_conv("t2 b3", 3, 12'd400, 12'd400);
        do_conv("t2 hp", 4, 12'd500, 12'd500);
        do_conv("t2 vol", 5, 12'd600, 12'd600);
        check("t2 done", 32'(scan_done), 32'd1);
        do_conv("t2 lp+4", 0, 12'd104, 12'd104);

        // 3: dropped completion on B2
        do_conv("t3 b1", 1, 12'd200, 12'd200);
        start_conv("t3 b2", 4, w);
        repeat (TMO) tick();
        check("t3 tmo before", 32'(tmo_err), 32'd0);
        tick();
        check("t3 tmo after", 32'(tmo_err), 32'd1);
        check("t3 b2 held", 32'(pot_b2), 32'd296);
        a2d.cnv_cmplt = 1'b1;
        a2d.res       = 12'hABC;
        tick();
        a2d.cnv_cmplt = 1'b0;
        start_conv("t3 b3", 2, w);
        check("t3 gap len", 32'(w), 32'(GAP - 1));
        check("t3 b2 stray", 32'(pot_b2), 32'd296);
        finish_conv(20, 12'd410);
        check("t3 b3 gain", 32'(pot_b3), 32'd410);
        do_conv("t3 hp", 4, 12'd500, 12'd500);
        do_conv("t3 vol", 5, 12'd600, 12'd600);
        do_conv("t3 lp", 0, 12'd104, 12'd104);

        // 4: en dropped mid-WAIT on B1
        start_conv("t4 b1", 0, w);
        repeat (5) tick();
        en = 1'b0;
        finish_conv(15, 12'd250);
        check("t4 b1 gain", 32'(pot_b1), 32'd250);
        strt_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (a2d.strt_cnv) strt_seen++;
            tick();
        end
        check("t4 no strt", 32'(strt_seen), 32'd0);
        en = 1'b1;
        start_conv("t4 resume", 4, w);
        check("t4 resume wait", 32'(w), 32'd1);
        finish_conv(20, 12'd300);
        check("t4 b2 gain", 32'(pot_b2), 32'd300);
        check("t4 tmo sticky", 32'(tmo_err), 32'd1);

        // 5: reset mid-WAIT, then a stray completion in IDLE
        start_conv("t5 b3", 2, w);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        tick();
        en  = 1'b0;
        rst = 1'b0;
        tick();
        a2d.cnv_cmplt = 1'b1;
        a2d.res       = 12'h777;
        tick();
        a2d.cnv_cmplt = 1'b0;
        repeat (2) tick();
        check("t5 lp", 32'(pot_lp), 32'd0);
        check("t5 b3", 32'(pot_b3), 32'd0);
        check("t5 vol", 32'(volume), 32'd0);
        check("t5 vld", 32'(gains_vld), 32'd0);
        check("t5 tmo", 32'(tmo_err), 32'd0);
        check("t5 chnnl", 32'(a2d.chnnl), 32'd1);
        check("t5 strt", 32'(a2d.strt_cnv), 32'd0);
        en = 1'b1;
        do_conv("t5 lp first", 0, 12'd3, 12'd3);

        // 6: completion on the exact watchdog expiry cycle
        start_conv("t6 b1", 0, w);
        finish_conv(TMO, 12'h123);
        check("t6 b1 gain", 32'(pot_b1), 32'h123);
        check("t6 tmo", 32'(tmo_err), 32'd0);
        repeat (5) tick();
        check("t6 tmo later", 32'(tmo_err), 32'd0);
        en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
